// File: rtl/bit_frame_encoder_pkg.sv
// Shared constants for the bit frame encoder.
// Optional frame counter enabled by BIT_FRAME_ENC_STATS_EN.
package bit_frame_encoder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FRAME = 2'd1;
  localparam logic [1:0] ST_TAIL  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam int MARKER_POS = 0;
  localparam int STATS_W    = 16;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bit_frame_encoder_gap_counter.sv
// Loadable down-counter with zero flag.
// Times the all-zero gap between frames.
module bfe_gap_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/bit_frame_encoder.sv
// Frames a valid/ready payload stream onto a marker-bit bus.
// BIT_FRAME_ENC_STATS_EN adds the frame_count output.
module bit_frame_encoder
  import bit_frame_encoder_pkg::*;
#(
  parameter int N         = 8,
  parameter int MIN_GAP   = 1,
  parameter int MAX_FRAME = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-2:0]       in_data,
  input  logic               in_last,
  output logic [N-1:0]       data_out,
  output logic               busy,
  output logic               frame_trunc
`ifdef BIT_FRAME_ENC_STATS_EN
  ,
  output logic [STATS_W-1:0] frame_count
`endif
);

  localparam int BW = cnt_w(MAX_FRAME);
  localparam int GW = cnt_w(MIN_GAP);
  localparam logic [N-1:0] MARK_WORD = N'(1) << MARKER_POS;
  localparam logic [GW-1:0] GAP_LOAD =
    (MIN_GAP > 0) ? GW'(MIN_GAP - 1) : '0;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [N-1:0]  data_q, data_d;
  logic          busy_q, busy_d;
  logic          trunc_q, trunc_d;

  logic accept;
  logic cnt_hit;
  logic terminal;
  logic gap_load;
  logic gap_dec;
  logic gap_zero;

  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_FRAME);
  assign accept   = in_valid && in_ready;
  assign cnt_hit  = (beat_cnt_q + BW'(1)) == BW'(MAX_FRAME);
  assign terminal = accept && (in_last || cnt_hit);

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    data_d     = '0;
    trunc_d    = 1'b0;
    gap_load   = 1'b0;
    gap_dec    = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE),
      (state_q == ST_FRAME): begin
        if (accept) begin
          data_d = {in_data, 1'b1};
          if (terminal) begin
            state_d    = ST_TAIL;
            beat_cnt_d = '0;
            trunc_d    = !in_last;
          end else begin
            state_d    = ST_FRAME;
            beat_cnt_d = beat_cnt_q + BW'(1);
          end
        end else if (state_q == ST_FRAME) begin
          // Stall keeps the frame open: marker only.
          data_d = MARK_WORD;
        end
      end
      (state_q == ST_TAIL): begin
        beat_cnt_d = '0;
        if (MIN_GAP == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_GAP;
          gap_load = 1'b1;
        end
      end
      (state_q == ST_GAP): begin
        if (gap_zero) begin
          state_d = ST_IDLE;
        end else begin
          gap_dec = 1'b1;
        end
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      trunc_q    <= trunc_d;
    end
  end

  bfe_gap_counter #(
    .W(GW)
  ) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  assign data_out    = data_q;
  assign busy        = busy_q;
  assign frame_trunc = trunc_q;

`ifdef BIT_FRAME_ENC_STATS_EN
  logic [STATS_W-1:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if ((state_d == ST_TAIL) && (state_q != ST_TAIL)) begin
      fcnt_d = fcnt_q + STATS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign frame_count = fcnt_q;
`endif

endmodule

// File: tb/tb_bit_frame_encoder.sv
// Directed and random frames against a per-cycle expectation list.
// Two instances: MIN_GAP=1/MAX_FRAME=4 and MIN_GAP=0/MAX_FRAME=16.
module tb_bit_frame_encoder;

  logic clk = 1'b0;
  logic rst;

  logic       a_valid, a_ready, a_last, a_busy, a_trunc;
  logic [6:0] a_data;
  logic [7:0] a_out;
  logic       b_valid, b_ready, b_last, b_busy, b_trunc;
  logic [6:0] b_data;
  logic [7:0] b_out;
`ifdef BIT_FRAME_ENC_STATS_EN
  logic [15:0] a_fc, b_fc;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bit_frame_encoder #(.N(8), .MIN_GAP(1), .MAX_FRAME(4)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (a_valid),
    .in_ready    (a_ready),
    .in_data     (a_data),
    .in_last     (a_last),
    .data_out    (a_out),
    .busy        (a_busy),
    .frame_trunc (a_trunc)
`ifdef BIT_FRAME_ENC_STATS_EN
    ,
    .frame_count (a_fc)
`endif
  );

  bit_frame_encoder #(.N(8), .MIN_GAP(0), .MAX_FRAME(16)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (b_valid),
    .in_ready    (b_ready),
    .in_data     (b_data),
    .in_last     (b_last),
    .data_out    (b_out),
    .busy        (b_busy),
    .frame_trunc (b_trunc)
`ifdef BIT_FRAME_ENC_STATS_EN
    ,
    .frame_count (b_fc)
`endif
  );

  // One entry per clock: inputs to drive and outputs expected after the edge.
  typedef struct {
    logic       v;
    logic [6:0] d;
    logic       l;
    logic       rdy;
    logic [7:0] out;
    logic       tr;
    logic       bz;
  } cyc_t;

  cyc_t cyc_q[$];
  int   m_cnt = 0;
  int   fc[2] = '{0, 0};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add_beat(input int sel, input logic [6:0] d,
                          input logic l);
    cyc_t c;
    int   mg;
    int   mf;
    bit   term;
    mg = (sel == 0) ? 1 : 0;
    mf = (sel == 0) ? 4 : 16;
    m_cnt++;
    term = l || (m_cnt == mf);
    c = '{1'b1, d, l, 1'b1, {d, 1'b1}, term && !l, 1'b1};
    cyc_q.push_back(c);
    if (term) begin
      m_cnt = 0;
      fc[sel]++;
      // Gap: a beat is offered but must not be taken.
      for (int g = 0; g <= mg; g++) begin
        c = '{1'b1, 7'($urandom), 1'($urandom), 1'b0, 8'h00, 1'b0, g < mg};
        cyc_q.push_back(c);
      end
    end
  endtask

  task automatic add_stall();
    cyc_t c;
    if (m_cnt > 0) c = '{1'b0, 7'($urandom), 1'b0, 1'b1, 8'h01, 1'b0, 1'b1};
    else c = '{1'b0, 7'($urandom), 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    cyc_q.push_back(c);
  endtask

  task automatic play(input int sel);
    cyc_t c;
    while (cyc_q.size() != 0) begin
      c = cyc_q.pop_front();
      if (sel == 0) begin
        a_valid = c.v; a_data = c.d; a_last = c.l;
      end else begin
        b_valid = c.v; b_data = c.d; b_last = c.l;
      end
      @(negedge clk);
      chk("in_ready", (sel == 0) ? a_ready : b_ready, c.rdy);
      @(posedge clk);
      #1;
      chk("data_out", (sel == 0) ? a_out : b_out, c.out);
      chk("busy", (sel == 0) ? a_busy : b_busy, c.bz);
      chk("frame_trunc", (sel == 0) ? a_trunc : b_trunc, c.tr);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic rand_frames(input int sel, input int nfr);
    int len;
    for (int f = 0; f < nfr; f++) begin
      len = $urandom_range(1, 7);
      if ($urandom_range(0, 3) == 0) add_stall();
      for (int i = 0; i < len; i++) begin
        if (m_cnt > 0 && $urandom_range(0, 2) == 0) add_stall();
        add_beat(sel, 7'($urandom), i == len - 1);
      end
    end
    play(sel);
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_a", a_out, 8'h00);
    chk("rst_busy_a", a_busy, 1'b0);
    chk("rst_trunc_a", a_trunc, 1'b0);
    chk("rst_out_b", b_out, 8'h00);
    chk("rst_busy_b", b_busy, 1'b0);
    rst = 1'b0;

    // Single-beat frame: 0x55 -> 0xAB, then two zeros with ready low.
    add_beat(0, 7'h55, 1'b1);
    play(0);

    // Frame with two stall cycles: 03 01 01 FF 01.
    add_beat(0, 7'h01, 1'b0);
    add_stall();
    add_stall();
    add_beat(0, 7'h7F, 1'b0);
    add_beat(0, 7'h00, 1'b1);
    play(0);

    // Six beats, last on the sixth: forced end after four.
    for (int i = 0; i < 6; i++) add_beat(0, 7'(8'h10 + i), i == 5);
    play(0);

    // Exactly MAX_FRAME beats with last also set: not truncated.
    for (int i = 0; i < 4; i++) add_beat(0, 7'(8'h20 + i), i == 3);
    play(0);

    // Back-to-back three-beat frames with MIN_GAP=0.
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 3; i++) add_beat(1, 7'(f * 16 + i), i == 2);
    play(1);

    // Sixteen beats without last on the wide instance.
    for (int i = 0; i < 17; i++) add_beat(1, 7'(8'h40 + i), i == 16);
    play(1);

    rand_frames(0, 12);
    rand_frames(1, 12);

`ifdef BIT_FRAME_ENC_STATS_EN
    chk("frame_count_a", a_fc, 32'(fc[0]));
    chk("frame_count_b", b_fc, 32'(fc[1]));
`endif

    // Reset in the middle of a frame.
    add_beat(0, 7'h11, 1'b0);
    add_beat(0, 7'h22, 1'b0);
    play(0);
    rst = 1'b1;
    a_valid = 1'b1; a_data = 7'h33; a_last = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out", a_out, 8'h00);
    chk("midrst_busy", a_busy, 1'b0);
    chk("midrst_trunc", a_trunc, 1'b0);
    rst = 1'b0;
    m_cnt = 0;
    fc[0] = 0;
    fc[1] = 0;
    add_beat(0, 7'h3C, 1'b1);
    play(0);
    rand_frames(0, 4);

`ifdef BIT_FRAME_ENC_STATS_EN
    chk("frame_count_rst", a_fc, 32'(fc[0]));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
